// File: rtl/sample_stream_player_pkg.sv
// Shared types and constants for the paced sample player.
package sample_stream_player_pkg;

  localparam int SAMPLE_W           = 8;
  localparam int SAMPLE_DIV_DEFAULT = 97;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_e;

endpackage

// File: rtl/sample_stream_player_fifo.sv
// Synchronous sample FIFO; memory is read through the registered read pointer.
module sample_fifo
  import sample_stream_player_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [SAMPLE_W-1:0] wr_data_i,
  input  logic                pop_i,
  output logic [SAMPLE_W-1:0] rd_data_o,
  output logic [ADDR_W:0]     level_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     level_q;
  logic                do_push, do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: the storage array has no reset so it can map onto block RAM;
  // only pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (ADDR_W+1)'(1);
        2'b01:   level_q <= level_q - (ADDR_W+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_data_o = mem[rd_ptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/sample_stream_player.sv
// Buffers producer samples and replays them on a bus paced at one sample
// every SAMPLE_DIV clocks, re-priming the FIFO after an underrun.
module sample_stream_player
  import sample_stream_player_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int SAMPLE_DIV  = SAMPLE_DIV_DEFAULT,
  parameter int PRIME_LEVEL = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic [SAMPLE_W-1:0] wr_data_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  output logic [SAMPLE_W-1:0] current_num_o,
  output logic                sample_strobe_o,
  output logic                playing_o,
  output logic                underrun_o,
  output logic [ADDR_W:0]     level_o
);

  localparam int               DIV_W     = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [ADDR_W:0]  PRIME_LVL = (ADDR_W+1)'(PRIME_LEVEL);

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [SAMPLE_W-1:0] cur_q, cur_d;
  logic                strobe_q, strobe_d;
  logic                underrun_q, underrun_d;
  logic                tick, pop;
  logic                fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] head;
  logic [ADDR_W:0]     level;

  sample_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (wr_valid_i),
    .wr_data_i (wr_data_i),
    .pop_i     (pop),
    .rd_data_o (head),
    .level_o   (level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign tick = (state_q == ST_PLAY) && (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: if (level >= PRIME_LVL) state_d = ST_PLAY;
        ST_PLAY:  if (tick && fifo_empty) state_d = ST_PRIME;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    div_d      = '0;
    cur_d      = cur_q;
    strobe_d   = 1'b0;
    underrun_d = underrun_q;
    pop        = 1'b0;
    if (!enable_i) begin
      cur_d      = '0;
      underrun_d = 1'b0;
    end else if (state_q == ST_PLAY) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          cur_d    = head;
          strobe_d = 1'b1;
        end else begin
          underrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      cur_q      <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      cur_q      <= cur_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    playing_o       = (state_q == ST_PLAY);
    wr_ready_o      = !fifo_full;
    current_num_o   = cur_q;
    sample_strobe_o = strobe_q;
    underrun_o      = underrun_q;
    level_o         = level;
  end

endmodule

// File: tb/tb_sample_stream_player.sv
// Bench for sample_stream_player: directed sequences on a default-parameter
// instance, plus a table and a queue-based reference model on a fast instance.
`timescale 1ns/1ps
module tb_sample_stream_player;

  localparam int DEPTH   = 1024;
  localparam int F_DIV   = 4;
  localparam int F_PRIME = 2;

  typedef struct packed {
    logic        rdy;
    logic [10:0] lvl;
    logic        ply;
    logic        und;
    logic        stb;
    logic [7:0]  cur;
  } obs_t;

  typedef struct {
    logic       en;
    logic       wv;
    logic [7:0] wd;
    obs_t       exp;
  } vec_t;

  localparam obs_t RST_OBS = '{rdy:1'b1, lvl:11'd0, ply:1'b0, und:1'b0, stb:1'b0, cur:8'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic d_en = 0, d_wv = 0; logic [7:0] d_wd = '0;
  logic d_rdy, d_stb, d_ply, d_und; logic [7:0] d_cur; logic [10:0] d_lvl;
  logic f_en = 0, f_wv = 0; logic [7:0] f_wd = '0;
  logic f_rdy, f_stb, f_ply, f_und; logic [7:0] f_cur; logic [10:0] f_lvl;

  sample_stream_player dut (
    .clk(clk), .rst(rst), .enable_i(d_en), .wr_data_i(d_wd), .wr_valid_i(d_wv),
    .wr_ready_o(d_rdy), .current_num_o(d_cur), .sample_strobe_o(d_stb),
    .playing_o(d_ply), .underrun_o(d_und), .level_o(d_lvl)
  );

  sample_stream_player #(
    .DEPTH(DEPTH), .ADDR_W(10), .SAMPLE_DIV(F_DIV), .PRIME_LEVEL(F_PRIME)
  ) dut_fast (
    .clk(clk), .rst(rst), .enable_i(f_en), .wr_data_i(f_wd), .wr_valid_i(f_wv),
    .wr_ready_o(f_rdy), .current_num_o(f_cur), .sample_strobe_o(f_stb),
    .playing_o(f_ply), .underrun_o(f_und), .level_o(f_lvl)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got rdy=%0b lvl=%0d ply=%0b und=%0b stb=%0b cur=%0h, expected rdy=%0b lvl=%0d ply=%0b und=%0b stb=%0b cur=%0h",
               name, got.rdy, got.lvl, got.ply, got.und, got.stb, got.cur,
               exp.rdy, exp.lvl, exp.ply, exp.und, exp.stb, exp.cur);
    end
  endtask

  function automatic obs_t d_obs();
    return '{rdy:d_rdy, lvl:d_lvl, ply:d_ply, und:d_und, stb:d_stb, cur:d_cur};
  endfunction

  function automatic obs_t f_obs();
    return '{rdy:f_rdy, lvl:f_lvl, ply:f_ply, und:f_und, stb:f_stb, cur:f_cur};
  endfunction

  function automatic vec_t mk(logic en, logic wv, logic [7:0] wd, logic rdy, int lvl,
                              logic ply, logic und, logic stb, logic [7:0] cur);
    vec_t v;
    v.en = en; v.wv = wv; v.wd = wd;
    v.exp = '{rdy:rdy, lvl:11'(lvl), ply:ply, und:und, stb:stb, cur:cur};
    return v;
  endfunction

  // One clock: inputs are already set, outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    d_en = 0; d_wv = 0; f_en = 0; f_wv = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic d_wait_strobe(input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!d_stb && n < bound);
    if (!d_stb) begin
      total++;
      bad++;
      $display("FAIL strobe_wait: no strobe within %0d cycles", n);
    end
  endtask

  // Reference model: FIFO as a queue, playback as mode + tick counter.
  logic [7:0] mq[$];
  int         m_mode;  // 0 idle, 1 priming, 2 playing
  int         m_cnt;
  logic [7:0] m_cur;
  logic       m_stb, m_und;

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_cnt = 0; m_cur = '0; m_stb = 0; m_und = 0;
  endtask

  task automatic model_step(input logic en, input logic wv, input logic [7:0] wd);
    int  sz;
    bit  accept;
    sz     = mq.size();
    accept = wv && (sz < DEPTH);
    m_stb  = 0;
    if (!en) begin
      m_mode = 0; m_cur = '0; m_und = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (sz >= F_PRIME) begin m_mode = 2; m_cnt = 0; end
    end else if (m_cnt == F_DIV - 1) begin
      m_cnt = 0;
      if (sz > 0) begin m_cur = mq.pop_front(); m_stb = 1; end
      else begin m_und = 1; m_mode = 1; end
    end else begin
      m_cnt++;
    end
    if (accept) mq.push_back(wd);
  endtask

  function automatic obs_t m_obs();
    return '{rdy:(mq.size() != DEPTH), lvl:11'(mq.size()), ply:(m_mode == 2),
             und:m_und, stb:m_stb, cur:m_cur};
  endfunction

  bit burst_phase = 0;
  int seq_next = 0;
  int seq_ok   = 0;

  task automatic fstep(input logic en, input logic wv, input logic [7:0] wd);
    f_en = en; f_wv = wv; f_wd = wd;
    model_step(en, wv, wd);
    step();
    check_obs("model_cycle", f_obs(), m_obs());
    if (burst_phase && f_stb) begin
      if (f_cur == 8'(seq_next)) seq_ok++;
      seq_next++;
    end
  endtask

  vec_t tbl[20];

  initial begin
    int n, cnt, guard;
    logic en_r;

    tbl[0]  = mk(1, 1, 8'h11, 1, 1, 0, 0, 0, 8'h00);
    tbl[1]  = mk(1, 1, 8'h22, 1, 2, 0, 0, 0, 8'h00);
    tbl[2]  = mk(1, 0, 8'h00, 1, 2, 1, 0, 0, 8'h00);
    tbl[3]  = mk(1, 0, 8'h00, 1, 2, 1, 0, 0, 8'h00);
    tbl[4]  = mk(1, 0, 8'h00, 1, 2, 1, 0, 0, 8'h00);
    tbl[5]  = mk(1, 0, 8'h00, 1, 2, 1, 0, 0, 8'h00);
    tbl[6]  = mk(1, 0, 8'h00, 1, 1, 1, 0, 1, 8'h11);
    tbl[7]  = mk(1, 1, 8'h00, 1, 2, 1, 0, 0, 8'h11);
    tbl[8]  = mk(1, 0, 8'h00, 1, 2, 1, 0, 0, 8'h11);
    tbl[9]  = mk(1, 0, 8'h00, 1, 2, 1, 0, 0, 8'h11);
    tbl[10] = mk(1, 0, 8'h00, 1, 1, 1, 0, 1, 8'h22);
    tbl[11] = mk(1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h22);
    tbl[12] = mk(1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h22);
    tbl[13] = mk(1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h22);
    tbl[14] = mk(1, 0, 8'h00, 1, 0, 1, 0, 1, 8'h00);
    tbl[15] = mk(1, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00);
    tbl[16] = mk(1, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00);
    tbl[17] = mk(1, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00);
    tbl[18] = mk(1, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00);
    tbl[19] = mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00);

    // Default instance: prime with 16 samples, paced playback, underrun.
    do_reset();
    check_obs("reset_default", d_obs(), RST_OBS);
    d_en = 1;
    for (int i = 1; i <= 16; i++) begin
      d_wv = 1; d_wd = 8'(i);
      step();
    end
    d_wv = 0;
    check("prime_level16", d_lvl, 16);
    check("prime_not_playing", d_ply, 0);
    step();
    check("playing_after_prime", d_ply, 1);
    for (int s = 1; s <= 16; s++) begin
      d_wait_strobe(200, n);
      check($sformatf("gap_sample%0d", s), n, 97);
      check($sformatf("value_sample%0d", s), d_cur, s);
    end

    cnt = 0;
    for (int k = 0; k < 96; k++) begin
      step();
      if (d_stb) cnt++;
    end
    check("no_strobe_before_tick", cnt, 0);
    check("still_playing_before_tick", d_ply, 1);
    step();
    check_obs("underrun_tick", d_obs(),
              '{rdy:1'b1, lvl:11'd0, ply:1'b0, und:1'b1, stb:1'b0, cur:8'd16});
    for (int i = 17; i <= 32; i++) begin
      d_wv = 1; d_wd = 8'(i);
      step();
    end
    d_wv = 0;
    d_wait_strobe(200, n);
    check("restart_latency", n, 98);
    check("restart_value", d_cur, 17);
    check("underrun_sticky", d_und, 1);
    d_en = 0;
    step();
    check_obs("disable_clears", d_obs(),
              '{rdy:1'b1, lvl:11'd15, ply:1'b0, und:1'b0, stb:1'b0, cur:8'd0});

    // Fill to DEPTH while disabled.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      d_wv = 1; d_wd = 8'(i + 1);
      step();
      if (i == DEPTH - 2) begin
        check("level_1023", d_lvl, 1023);
        check("ready_at_1023", d_rdy, 1);
      end
    end
    check("level_full", d_lvl, 1024);
    check("ready_low_full", d_rdy, 0);
    d_wd = 8'hEE;
    step();
    check_obs("extra_write_rejected", d_obs(),
              '{rdy:1'b0, lvl:11'd1024, ply:1'b0, und:1'b0, stb:1'b0, cur:8'd0});

    // Full FIFO: pop at tick while writer is still valid.
    d_wd = 8'hAB; d_en = 1;
    d_wait_strobe(300, n);
    check("full_first_latency", n, 99);
    check("full_first_value", d_cur, 1);
    check("full_pop_no_push_level", d_lvl, 1023);
    check("full_pop_ready", d_rdy, 1);
    step();
    check("refill_level", d_lvl, 1024);
    check("refill_ready", d_rdy, 0);
    d_wv = 0;
    d_wait_strobe(200, n);
    check("second_gap", n, 96);
    check("second_value", d_cur, 2);
    check("second_level", d_lvl, 1023);
    repeat (96) step();
    d_wv = 1; d_wd = 8'hCD;
    step();
    d_wv = 0;
    check_obs("push_pop_same_tick", d_obs(),
              '{rdy:1'b1, lvl:11'd1023, ply:1'b1, und:1'b0, stb:1'b1, cur:8'd3});

    // Asynchronous reset in the middle of playback.
    #3 rst = 1'b1;
    #1 check_obs("async_reset_immediate", d_obs(), RST_OBS);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (d_stb || d_ply) cnt++;
    end
    check("after_reset_waits_in_prime", cnt, 0);
    check("after_reset_level", d_lvl, 0);
    d_en = 0;

    // Fast instance: stimulus table.
    do_reset();
    check_obs("reset_fast", f_obs(), RST_OBS);
    for (int i = 0; i < 20; i++) begin
      f_en = tbl[i].en; f_wv = tbl[i].wv; f_wd = tbl[i].wd;
      step();
      check_obs($sformatf("table_row%0d", i), f_obs(), tbl[i].exp);
    end

    // Fast instance: 1100-sample counting burst across pointer wrap.
    do_reset();
    model_reset();
    burst_phase = 1;
    for (int i = 0; i < 1100; i++) fstep(1, 1, 8'(i));
    guard = 0;
    while (mq.size() != 0 && guard < 5000) begin
      fstep(1, 0, 8'h00);
      guard++;
    end
    repeat (8) fstep(1, 0, 8'h00);
    burst_phase = 0;
    check("drain_within_bound", (guard < 5000), 1);
    check("burst_order_count", seq_ok, 1100);

    // Fast instance: randomized traffic with occasional enable toggles.
    en_r = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) en_r = ~en_r;
      fstep(en_r, ($urandom_range(0, 99) < 35), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_stream_player.md
Name: sample_stream_player

Overview:
- Transmit-side counterpart of the sample capture path: buffers 8-bit samples pushed by a producer (SD reader / test pattern source) and emits them on a paced parallel sample bus, one sample every SAMPLE_DIV clocks.
- The output bus follows the capture-side convention: value 0 means idle/no data, and a capture block arms on the first nonzero sample.
- Sits between the sample source and the capture/playback consumer; also serves as a loopback stimulus generator for the capture block on the board.

Parameters:
- DEPTH, 1024, FIFO depth in samples; power of two.
- ADDR_W, 10, log2(DEPTH).
- SAMPLE_DIV, 97, clocks per output sample; must be >= 2.
- PRIME_LEVEL, 16, FIFO occupancy required before playback (re)starts; 1..DEPTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  level; 1 = run, 0 = return to IDLE.
- wr_data  in  8  sample from producer.
- wr_valid  in  1  producer has a sample.
- wr_ready  out  1  FIFO can accept; a transfer occurs when wr_valid && wr_ready.
- current_num  out  8  paced sample output; registered.
- sample_strobe  out  1  one-cycle pulse in the cycle current_num takes a new value.
- playing  out  1  high in PLAY.
- underrun  out  1  sticky flag; FIFO empty at a sample tick.
- level  out  ADDR_W+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release): state=IDLE, FIFO empty, level=0, wr_ready=1, current_num=0, sample_strobe=0, playing=0, underrun=0, divider=0.
- FIFO:
  - Write accepted whenever level<DEPTH, in any state including IDLE; wr_ready = (level!=DEPTH), combinational from registered level.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle: both occur and level is unchanged. This also applies when full: the pop frees a slot, but wr_ready is still 0 that cycle, so no push occurs.
- States:
  - IDLE: current_num=0, divider held at 0. Moves to PRIME when enable=1.
  - PRIME: waits until level>=PRIME_LEVEL, then moves to PLAY with divider=0. current_num holds its last value (0 after IDLE).
  - PLAY: divider counts 0..SAMPLE_DIV-1 and wraps. The tick is the cycle with divider==SAMPLE_DIV-1.
    - Tick with level>0: pop; current_num <= head sample on the next edge; sample_strobe=1 in that same cycle.
    - Tick with level==0: underrun<=1; current_num holds its value; no strobe; go to PRIME.
  - enable=0 in any state: next state IDLE, current_num<=0, underrun<=0, divider<=0. FIFO contents are retained.
- Latency:
  - The first sample appears exactly SAMPLE_DIV clocks after the PRIME->PLAY transition edge.
  - Consecutive strobes are exactly SAMPLE_DIV clocks apart while the FIFO is not empty.
- A sample value of 0 is passed through unchanged; the player does not filter it.
- Reset asserted mid-operation: all state and FIFO contents are discarded immediately.

Decomposition:
- Shared package: state enum (IDLE, PRIME, PLAY), sample width constant SAMPLE_W=8, default SAMPLE_DIV=97.
- One sub-module, sample_fifo: synchronous FIFO with params DEPTH/ADDR_W, push/pop, level, full/empty, and a registered-pointer memory that infers BRAM.
- The player holds only the FSM, the divider and the output register.

Test Plan:
- Reset, enable=1, push 16 samples 1..16 back-to-back -> playing rises after the 16th write; current_num = 1,2,...,16 with strobes 97 clocks apart; first strobe 97 clocks after PRIME->PLAY.
- After the previous scenario drains, no further writes -> at the tick following sample 16, underrun=1, current_num holds 16, state=PRIME, no strobe; then push 16 more -> playback resumes and underrun stays 1.
- enable=0 with enable held low, push 1024 samples -> wr_ready=0 at level=1024; a 1025th wr_valid is not accepted; current_num stays 0.
- With the FIFO full, enable=1 -> at a tick, a simultaneous pop and wr_valid pushes nothing that cycle; wr_ready=1 the next cycle and level=1023.
- In PLAY, write and pop on the same tick cycle -> level unchanged; data order preserved across pointer wrap (write 1100 samples total with a counting pattern, check the output sequence).
- Assert rst for 1 clock mid-PLAY, asynchronously off the clock edge -> all outputs go to reset values immediately; level=0; after release with enable=1, the block waits in PRIME.
